// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side burst controller for the 256x8 data memory.
// It takes burst read/write commands over a valid/ready request channel,
// streams write beats in and read beats out with per-beat handshakes, and is
// the only agent that drives the memory control pins.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           command handshake (ready only in IDLE)
//   req_we, req_addr, req_len     direction, start address, beats minus one
//   wr_valid/wr_ready, wr_data    write beat stream (ready while in WR)
//   rd_valid/rd_ready, rd_data    read beat stream (registered data)
//   busy, done                    not-idle flag, one-cycle completion pulse
//   read_addr, write_addr, acc,   memory pins (mem_ren_wen: 0=read, 1=write)
//   mem_ren_wen, mem_output       mem_output is combinational read data
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_addr,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] acc,
    output logic              mem_ren_wen,
    input  logic [DATA_W-1:0] mem_output
);

    typedef enum logic [1:0] {IDLE, WR, RD, RD_RSP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   acc_hold_q, acc_hold_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            acc_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            beat_cnt_q <= beat_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            acc_hold_q <= acc_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        beat_cnt_d  = beat_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        acc_hold_d  = acc_hold_q;
        done_d      = 1'b0;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        mem_ren_wen = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_addr_d = req_addr;
                    beat_cnt_d = req_len;
                    state_d    = req_we ? WR : RD;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    // Memory commits on this same edge.
                    mem_ren_wen = 1'b1;
                    acc_hold_d  = wr_data;
                    cur_addr_d  = cur_addr_q + 1'b1;
                    // Test for zero before decrementing so len=F gives
                    // exactly 16 beats and the counter never wraps.
                    if (beat_cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            RD: begin
                rd_data_d  = mem_output;
                rd_valid_d = 1'b1;
                state_d    = RD_RSP;
            end
            RD_RSP: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    cur_addr_d = cur_addr_q + 1'b1;
                    if (beat_cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                        state_d    = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write data is passed straight through in WR so the memory sees it on the
    // accepting edge; elsewhere acc just holds the last written value.
    assign acc        = (state_q == WR) ? wr_data : acc_hold_q;
    assign read_addr  = cur_addr_q;
    assign write_addr = cur_addr_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule
